// File: rtl/shift_unit_ctrl.sv
// Sequencing front-end for a 16-bit combinational barrel shifter: accepts a shift
// request, drives one or two shifter passes, and returns a registered result.
module shift_unit_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_data,
  input  logic [15:0] req_amt,
  output logic [15:0] sh_in,
  output logic [15:0] sh_shift,
  output logic        sh_lr,
  input  logic [15:0] sh_out,
  input  logic        sh_ov,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_ov,
  output logic        rsp_zero
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROL = 2'b11} op_t;

  state_t      r_state;
  state_t      w_next;
  op_t         r_op;
  op_t         w_req_op;
  logic [15:0] r_data;
  logic [3:0]  r_n;
  logic [15:0] r_acc;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_data;
  logic        r_rsp_ov;
  logic        r_rsp_zero;

  logic        w_accept;
  logic        w_big;
  logic        w_bypass;
  logic [15:0] w_byp_data;
  logic        w_byp_ov;
  logic [15:0] w_p1_data;
  logic        w_p1_ov;
  logic [15:0] w_rol_mask;
  logic [15:0] w_p2_data;
  logic [3:0]  w_n_comp;

  assign w_req_op = op_t'(req_op);
  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_big     = |req_amt[15:4];

  // Saturated shifts and zero-amount rotates resolve without touching the shifter.
  always_comb begin
    w_bypass   = 1'b0;
    w_byp_data = '0;
    w_byp_ov   = 1'b0;
    unique case (w_req_op)
      OP_SLL: begin
        w_bypass = w_big;
        w_byp_ov = w_big && req_data[15];
      end
      OP_SRL: w_bypass = w_big;
      OP_SRA: begin
        w_bypass   = w_big;
        w_byp_data = {16{req_data[15]}};
      end
      OP_ROL: begin
        w_bypass   = (req_amt[3:0] == 4'd0);
        w_byp_data = req_data;
      end
    endcase
  end

  // The shifter only right-shifts arithmetically; SRL clears the replicated sign bits.
  always_comb begin
    w_p1_data = sh_out;
    w_p1_ov   = 1'b0;
    unique case (r_op)
      OP_SLL: w_p1_ov = sh_ov;
      OP_SRL: w_p1_data = sh_out & (16'hFFFF >> r_n);
      default: w_p1_data = sh_out;
    endcase
  end

  assign w_n_comp   = 4'd0 - r_n;
  assign w_rol_mask = (16'd1 << r_n) - 16'd1;
  assign w_p2_data  = r_acc | (sh_out & w_rol_mask);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_next = w_bypass ? DONE : PASS1;
      PASS1: w_next = (r_op == OP_ROL) ? PASS2 : DONE;
      PASS2: w_next = DONE;
      DONE:  if (rsp_ready) w_next = IDLE;
    endcase
  end

  always_comb begin
    sh_in    = '0;
    sh_shift = '0;
    sh_lr    = 1'b0;
    unique case (r_state)
      PASS1: begin
        sh_in    = r_data;
        sh_shift = {12'b0, r_n};
        sh_lr    = (r_op == OP_SLL) || (r_op == OP_ROL);
      end
      PASS2: begin
        sh_in    = r_data;
        sh_shift = {12'b0, w_n_comp};
        sh_lr    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_SLL;
      r_data      <= '0;
      r_n         <= '0;
      r_acc       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_ov    <= 1'b0;
      r_rsp_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= w_req_op;
            r_data <= req_data;
            r_n    <= req_amt[3:0];
            if (w_bypass) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_byp_data;
              r_rsp_ov    <= w_byp_ov;
              r_rsp_zero  <= (w_byp_data == 16'd0);
            end
          end
        end
        PASS1: begin
          if (r_op == OP_ROL) begin
            r_acc <= sh_out;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_p1_data;
            r_rsp_ov    <= w_p1_ov;
            r_rsp_zero  <= (w_p1_data == 16'd0);
          end
        end
        PASS2: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_p2_data;
          r_rsp_ov    <= 1'b0;
          r_rsp_zero  <= (w_p2_data == 16'd0);
        end
        DONE: if (rsp_ready) r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_ov    = r_rsp_ov;
  assign rsp_zero  = r_rsp_zero;

endmodule

// File: doc/shift_unit_ctrl.md
# shift_unit_ctrl

Sequencing front-end for the 16-bit combinational barrel shifter in the CPU execute path. It accepts a shift request over a valid/ready handshake and drives the shifter's data, amount and direction inputs for one or two passes. It post-processes the shifter output into logical-right, saturated (amount ≥ 16) and rotate results. The final result and flags are returned over a registered valid/ready response port.

## Interface
- No parameters; datapath fixed at 16 bits.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
- req_data  in  16  operand
- req_amt  in  16  shift amount, unsigned
- sh_in  out  16  to shifter data input
- sh_shift  out  16  to shifter amount input; upper 12 bits always 0
- sh_lr  out  1  to shifter direction (1 = left, 0 = arithmetic right)
- sh_out  in  16  shifter result, combinational from sh_in/sh_shift/sh_lr
- sh_ov  in  1  shifter overflow (left: in[15] != out[15])
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer takes result
- rsp_data  out  16  result
- rsp_ov  out  1  overflow, SLL only
- rsp_zero  out  1  rsp_data == 0

## Operation
- FSM states: IDLE, PASS1, PASS2, DONE.
- req_ready is 1 only when the state is IDLE and rst = 0. Accept occurs when req_valid and req_ready are both 1. On accept, capture op, data and n = req_amt[3:0]. Also capture big = (req_amt ≥ 16).
- Bypass at accept, going IDLE→DONE directly and loading rsp_* at the same edge:
  - SLL/SRL with big: result 0x0000.
  - SRA with big: result {16{data[15]}}.
  - ROL with n = 0: result data.
  - ov = data[15] for SLL with big; otherwise 0.
- All other requests go IDLE→PASS1.
- PASS1 drives sh_in = data and sh_shift = {12'b0, n}:
  - sh_lr = 1 for SLL and ROL; 0 for SRL and SRA.
  - At the end of the cycle, SLL loads result = sh_out, ov = sh_ov.
  - SRA loads result = sh_out.
  - SRL loads result = sh_out & (0xFFFF >> n).
  - SLL/SRL/SRA then go →DONE. ROL latches A = sh_out and goes →PASS2.
- PASS2 (ROL only) drives sh_in = data, sh_shift = {12'b0, 16−n}, sh_lr = 0.
  - Result = A | (sh_out & ((1 << n) − 1)), ov = 0, then →DONE.
- DONE holds rsp_valid = 1 with rsp_data/rsp_ov/rsp_zero stable. On rsp_valid and rsp_ready, go →IDLE and clear rsp_valid.
- sh_in, sh_shift and sh_lr are 0 in IDLE and DONE (decoded combinationally from state).
- rsp_zero is registered together with rsp_data.
- ROL ignores req_amt[15:4]; the rotate amount is taken mod 16.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 0x0000, rsp_ov 0, rsp_zero 0, internal capture registers 0. req_ready is 0 while rst = 1.
- Latency from the accept edge k to rsp_valid high:
  - Bypass: edge k+1.
  - SLL/SRL/SRA: edge k+2.
  - ROL with n ≠ 0: edge k+3.
- No overlap: req_ready is 0 from accept until the response handoff. The next accept can occur no earlier than the cycle after handoff, when the state is IDLE.
- The response may be held indefinitely by rsp_ready = 0, with no change to any rsp_* output.
- rsp_ready = 1 outside DONE has no effect. Changes on req_* outside IDLE have no effect.
- rst = 1 in any state returns to IDLE at that edge. Any in-flight request is discarded and no response is produced. rst takes priority over handoff and accept in the same cycle.

## Test plan
- SLL, 0x4001, amt 1 → rsp_data 0x8002, ov 1, zero 0, rsp_valid at k+2; during PASS1, sh_lr = 1 and sh_shift = 0x0001.
- SRL then SRA, 0x8000, amt 4 → SRL gives 0x0800 (shifter returns 0xF800, then masked); SRA gives 0xF800, ov 0.
- Saturation: SRA 0x8001, amt 20 → 0xFFFF at k+1. SLL 0x8001, amt 16 → 0x0000, ov 1, zero 1, at k+1, with no shifter pass (sh_* stay 0).
- ROL 0x8001, amt 1 → 0x0003 at k+3. ROL 0x1234, amt 0x0014 (n = 4) → 0x2341; PASS2 drives sh_shift = 12, sh_lr = 0. ROL 0xBEEF, amt 0x0010 → 0xBEEF at k+1.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid → rsp_* stable, req_ready 0, and a pending req_valid is not accepted until the cycle after handoff.
- Reset during PASS2 of a ROL → IDLE next edge, rsp_valid stays 0, no stale response; a fresh SLL, 0x0001, amt 3 then returns 0x0008.
